// File: rtl/brush_stamper.sv
// Stamps a 13-point diamond brush around a captured cursor: first pixel one cycle after start, 13 cycles with pix_ready=1, then a 1-cycle done.
// pix_valid/px/py hold while pix_ready=0; BRUSH_CLIP_EN skips off-screen points in one cycle each without waiting on pix_ready.
module brush_stamper #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic signed [15:0] cx,
  input  logic signed [15:0] cy,
  output logic signed [15:0] px,
  output logic signed [15:0] py,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t             state, state_nx;
  logic [3:0]         idx;
  logic signed [15:0] cx_reg, cy_reg;
  logic signed [15:0] dx, dy;
  logic signed [15:0] sum_x, sum_y;
  logic               in_screen;
  logic               advance;
  logic               last;

  if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_size
    $error("brush_stamper: screen dimensions must be positive");
  end

  always_comb begin
    dx = 16'sd0;
    dy = 16'sd0;
    case (idx)
      4'd0:    begin dx =  16'sd0; dy = -16'sd2; end
      4'd1:    begin dx =  16'sd0; dy = -16'sd1; end
      4'd2:    begin dx =  16'sd0; dy =  16'sd0; end
      4'd3:    begin dx =  16'sd0; dy =  16'sd1; end
      4'd4:    begin dx =  16'sd0; dy =  16'sd2; end
      4'd5:    begin dx =  16'sd1; dy = -16'sd1; end
      4'd6:    begin dx =  16'sd1; dy =  16'sd0; end
      4'd7:    begin dx =  16'sd1; dy =  16'sd1; end
      4'd8:    begin dx = -16'sd1; dy = -16'sd1; end
      4'd9:    begin dx = -16'sd1; dy =  16'sd0; end
      4'd10:   begin dx = -16'sd1; dy =  16'sd1; end
      4'd11:   begin dx =  16'sd2; dy =  16'sd0; end
      4'd12:   begin dx = -16'sd2; dy =  16'sd0; end
      default: begin dx =  16'sd0; dy =  16'sd0; end
    endcase
  end

  // 16-bit wrap-around is intentional: no saturation at the coordinate limits.
  assign sum_x = cx_reg + dx;
  assign sum_y = cy_reg + dy;

  always_comb begin
    in_screen = 1'b1;
`ifdef BRUSH_CLIP_EN
    in_screen = (int'(sum_x) >= 0) && (int'(sum_x) < SCREEN_W) &&
                (int'(sum_y) >= 0) && (int'(sum_y) < SCREEN_H);
`endif
  end

  assign last    = (idx == 4'd12);
  assign advance = (state == EMIT) && (pix_ready || !in_screen);

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = EMIT;
      EMIT:    if (advance && last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      idx    <= 4'd0;
      cx_reg <= 16'sd0;
      cy_reg <= 16'sd0;
    end else if (state == IDLE && start) begin
      idx    <= 4'd0;
      cx_reg <= cx;
      cy_reg <= cy;
    end else if (advance) begin
      idx <= last ? 4'd0 : idx + 4'd1;
    end
  end

  always_comb begin
    pix_valid = (state == EMIT) && in_screen;
    busy      = (state != IDLE);
    done      = (state == DONE);
    px        = (state == EMIT) ? sum_x : 16'sd0;
    py        = (state == EMIT) ? sum_y : 16'sd0;
  end

endmodule

// File: tb/tb_brush_stamper.sv
// Directed bench for brush_stamper: nominal stamp, stalls, ignored restart, clear abort, edge/clip cases.
module tb_brush_stamper;

  logic               clock = 1'b0;
  logic               clear, start, pix_ready;
  logic signed [15:0] cx, cy;
  logic signed [15:0] px, py;
  logic               pix_valid, busy, done;

  int checks = 0;
  int errors = 0;
  int exp_x[13];
  int exp_y[13];

  brush_stamper dut (
    .clock(clock), .clear(clear), .start(start), .cx(cx), .cy(cy),
    .px(px), .py(py), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_nominal();
    exp_x = '{100, 100, 100, 100, 100, 101, 101, 101,  99,  99,  99, 102,  98};
    exp_y = '{ 48,  49,  50,  51,  52,  49,  50,  51,  49,  50,  51,  50,  50};
  endtask

  task automatic do_start(input int x, input int y);
    cx = 16'(x); cy = 16'(y); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expects exp_x/exp_y on cycles 1..13 with pix_ready=1, done on 14, idle on 15.
  task automatic run_full(input string tag);
    for (int i = 0; i < 13; i++) begin
      chk({tag, "_valid"}, pix_valid, 1);
      chk({tag, "_px"}, px, exp_x[i]);
      chk({tag, "_py"}, py, exp_y[i]);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done_early"}, done, 0);
      tick();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_busy"}, busy, 1);
    chk({tag, "_done_valid"}, pix_valid, 0);
    tick();
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_done"}, done, 0);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; pix_ready = 1'b1; cx = 16'sd0; cy = 16'sd0;
    tick();
    tick();
    chk("rst_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_px", px, 0);
    chk("rst_py", py, 0);
    clear = 1'b0;
    tick();

    // Nominal stamp at (100,50).
    set_nominal();
    pix_ready = 1'b1;
    do_start(100, 50);
    run_full("nominal");

    // Stall every other cycle: each point shown twice, index holds during stall.
    do_start(100, 50);
    for (int i = 0; i < 13; i++) begin
      pix_ready = 1'b0;
      chk("stall_valid", pix_valid, 1);
      chk("stall_px", px, exp_x[i]);
      chk("stall_py", py, exp_y[i]);
      chk("stall_done", done, 0);
      tick();
      pix_ready = 1'b1;
      chk("held_valid", pix_valid, 1);
      chk("held_px", px, exp_x[i]);
      chk("held_py", py, exp_y[i]);
      tick();
    end
    chk("stall_end_done", done, 1);
    tick();
    chk("stall_end_busy", busy, 0);

    // Restart and cursor motion during a stamp have no effect.
    do_start(100, 50);
    start = 1'b1; cx = 16'sd7; cy = 16'sd9;
    for (int i = 0; i < 13; i++) begin
      chk("busy_ign_px", px, exp_x[i]);
      chk("busy_ign_py", py, exp_y[i]);
      tick();
    end
    chk("busy_ign_done", done, 1);
    start = 1'b0;
    tick();
    chk("busy_ign_idle", busy, 0);
    tick();
    chk("busy_ign_noreq", busy, 0);
    chk("busy_ign_novalid", pix_valid, 0);

    // Clear after five accepted pixels aborts cleanly.
    do_start(100, 50);
    for (int i = 0; i < 5; i++) begin
      chk("abort_px", px, exp_x[i]);
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_valid", pix_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_px0", px, 0);
    chk("abort_py0", py, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_nodone", done, 0);
      chk("abort_quiet", pix_valid, 0);
    end
    do_start(100, 50);
    run_full("after_abort");

`ifdef BRUSH_CLIP_EN
    // Corner stamp: only on-screen points appear, in footprint order.
    begin
      int ex[6] = '{0, 0, 0, 1, 1, 2};
      int ey[6] = '{0, 1, 2, 0, 1, 0};
      int n = 0;
      logic vis[13] = '{0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0};
      do_start(0, 0);
      for (int i = 0; i < 13; i++) begin
        chk("clip_valid", pix_valid, vis[i]);
        if (vis[i]) begin
          chk("clip_px", px, ex[n]);
          chk("clip_py", py, ey[n]);
          n++;
        end
        tick();
      end
      chk("clip_done", done, 1);
      tick();
      chk("clip_idle", busy, 0);
    end
    // Fully off-screen: no pixels, done still pulses 14 cycles after start.
    do_start(-10, -10);
    for (int i = 0; i < 13; i++) begin
      chk("allclip_valid", pix_valid, 0);
      chk("allclip_busy", busy, 1);
      chk("allclip_nodone", done, 0);
      tick();
    end
    chk("allclip_done", done, 1);
    tick();
    chk("allclip_idle", busy, 0);
`else
    // Corner stamp without clipping emits negative coordinates too.
    exp_x = '{0, 0, 0, 0, 0, 1, 1, 1, -1, -1, -1, 2, -2};
    exp_y = '{-2, -1, 0, 1, 2, -1, 0, 1, -1, 0, 1, 0, 0};
    do_start(0, 0);
    run_full("corner");

    // Coordinate wrap at the signed 16-bit limits.
    exp_x = '{32767, 32767, 32767, 32767, 32767, -32768, -32768, -32768,
              32766, 32766, 32766, -32767, 32765};
    exp_y = '{32766, 32767, -32768, -32767, -32766, 32767, -32768, -32767,
              32767, -32768, -32767, -32768, -32768};
    do_start(32767, -32768);
    run_full("wrap");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
